phy_tx_arbiter: RTL and testbench

Two-requester transmit arbiter and start-up sequencer in front of the 32-bit PHY transmit input (`data_in`/`valid_in` of the PHY). It holds the PHY idle for a fixed link-settle window after reset, then shares the single word-rate path between two requesters using round-robin bursts with a valid/ready handshake. Runs entirely in the `clk_2f` word-clock domain.

---
 rtl/phy_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_phy_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_arbiter.sv
// Two-requester round-robin burst arbiter feeding the 32-bit PHY transmit input.
// Holds the PHY idle for INIT_CYCLES edges after reset, then grants bursts of up to BURST_MAX words.
module phy_tx_arbiter #(
  parameter int unsigned INIT_CYCLES = 8,
  parameter int unsigned BURST_MAX   = 4
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [1:0]  grant,
  output logic        link_ready
);

  localparam int unsigned InitW  = $clog2(INIT_CYCLES + 1);
  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);
  localparam logic [InitW-1:0]  InitLast  = InitW'(INIT_CYCLES - 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_MAX - 1);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_GRANT0 = 2'd2;
  localparam logic [1:0] ST_GRANT1 = 2'd3;

  logic [1:0]        r_state;
  logic [InitW-1:0]  r_init_cnt;
  logic [BurstW-1:0] r_burst_cnt;
  logic              r_last;  // last-served requester: 0 = req0, 1 = req1
  logic              r_link_ready;
  logic [31:0]       r_data_out;
  logic              r_valid_out;

  logic [1:0]        w_state_d;
  logic [InitW-1:0]  w_init_d;
  logic [BurstW-1:0] w_burst_d;
  logic              w_last_d;
  logic              w_link_d;
  logic              w_own_id;
  logic              w_own_valid;
  logic              w_oth_valid;
  logic              w_exhaust;
  logic              w_xfer;
  logic [31:0]       w_xfer_data;

  assign w_own_id    = (r_state == ST_GRANT1);
  assign w_own_valid = w_own_id ? req1_valid : req0_valid;
  assign w_oth_valid = w_own_id ? req0_valid : req1_valid;
  assign w_xfer      = ((r_state == ST_GRANT0) && req0_valid) ||
                       ((r_state == ST_GRANT1) && req1_valid);
  assign w_xfer_data = w_own_id ? req1_data : req0_data;
  assign w_exhaust   = w_xfer && (r_burst_cnt == BurstLast);

  always_comb begin
    w_state_d = r_state;
    w_init_d  = r_init_cnt;
    w_burst_d = r_burst_cnt;
    w_last_d  = r_last;
    w_link_d  = r_link_ready;
    case (r_state)
      ST_INIT: begin
        w_init_d = r_init_cnt + 1'b1;
        if (r_init_cnt == InitLast) begin
          w_state_d = ST_IDLE;
          w_link_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        w_burst_d = '0;
        if (req0_valid && req1_valid) begin
          w_state_d = r_last ? ST_GRANT0 : ST_GRANT1;
        end else if (req0_valid) begin
          w_state_d = ST_GRANT0;
        end else if (req1_valid) begin
          w_state_d = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!w_own_valid || w_exhaust) begin
          w_last_d  = w_own_id;
          w_burst_d = '0;
          // Other side wins a release; an exhausted but still-valid owner re-grants without a bubble.
          if (w_oth_valid) begin
            w_state_d = w_own_id ? ST_GRANT0 : ST_GRANT1;
          end else if (!w_exhaust) begin
            w_state_d = ST_IDLE;
          end
        end else begin
          w_burst_d = r_burst_cnt + 1'b1;
        end
      end
      default: w_state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_last       <= 1'b1;
      r_link_ready <= 1'b0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_init_cnt   <= w_init_d;
      r_burst_cnt  <= w_burst_d;
      r_last       <= w_last_d;
      r_link_ready <= w_link_d;
      r_valid_out  <= w_xfer;
      if (w_xfer) begin
        r_data_out <= w_xfer_data;
      end
    end
  end

  assign req0_ready = (r_state == ST_GRANT0);
  assign req1_ready = (r_state == ST_GRANT1);
  assign grant      = {req1_ready, req0_ready};
  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign link_ready = r_link_ready;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter: INIT window, streaming, contention, idle release,
// mid-burst reset, and a BURST_MAX=1 instance for strict alternation.
module tb_phy_tx_arbiter;

  logic        clk_2f;
  logic        reset;
  logic [31:0] req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  grant;
  logic        link_ready;

  logic        d1_rdy0, d1_rdy1;
  logic [31:0] d1_data;
  logic        d1_valid;
  logic [1:0]  d1_grant;
  logic        d1_link;

  logic [31:0] q0 [16];
  logic [31:0] q1 [16];
  int          idx0, idx1, n0, n1;
  logic        en0, en1;
  logic        sel1;
  int          vectors;
  int          errs;

  phy_tx_arbiter #(.INIT_CYCLES(8), .BURST_MAX(4)) u_dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .grant      (grant),
    .link_ready (link_ready)
  );

  phy_tx_arbiter #(.INIT_CYCLES(8), .BURST_MAX(1)) u_dut1 (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (d1_rdy0),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (d1_rdy1),
    .data_out   (d1_data),
    .valid_out  (d1_valid),
    .grant      (d1_grant),
    .link_ready (d1_link)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid = en0 && (idx0 < n0);
    req1_valid = en1 && (idx1 < n1);
    req0_data  = q0[idx0 % 16];
    req1_data  = q1[idx1 % 16];
  endtask

  // Sources advance on a handshake with the instance selected by sel1.
  task automatic tick();
    logic h0, h1;
    h0 = req0_valid && (sel1 ? d1_rdy0 : req0_ready);
    h1 = req1_valid && (sel1 ? d1_rdy1 : req1_ready);
    @(posedge clk_2f);
    #1;
    if (h0) idx0++;
    if (h1) idx1++;
    drive();
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    sel1    = 1'b0;
    reset   = 1'b0;
    en0 = 1'b0; en1 = 1'b0; idx0 = 0; idx1 = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 16; i++) begin
      q0[i] = '0;
      q1[i] = '0;
    end
    drive();
    #2;
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_link", {31'b0, link_ready}, 32'h0);
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);

    // INIT window with req0 already valid
    q0[0] = 32'h1234_5678; n0 = 16; en0 = 1'b1; drive();
    tick(); tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("init_link", {31'b0, link_ready}, (k == 8) ? 32'h1 : 32'h0);
      chk("init_valid", {31'b0, valid_out}, 32'h0);
      chk("init_grant", {30'b0, grant}, 32'h0);
    end
    chk("init_idx0", idx0, 32'h0);
    en0 = 1'b0; drive();

    // Contention: 4 x req0, 4 x req1, alternating, req0 first
    for (int i = 0; i < 16; i++) begin
      q0[i] = 32'hA000_0000 + i;
      q1[i] = 32'hB000_0000 + i;
    end
    idx0 = 0; idx1 = 0; n0 = 8; n1 = 8; en0 = 1'b1; en1 = 1'b1; drive();
    tick();
    chk("cont_grant0", {30'b0, grant}, 32'h1);
    chk("cont_gap", {31'b0, valid_out}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      int b;
      int nb;
      b  = i / 4;
      nb = (i + 1) / 4;
      tick();
      chk("cont_data", data_out,
          (b % 2 == 0) ? (32'hA000_0000 + (b / 2) * 4 + i % 4)
                       : (32'hB000_0000 + (b / 2) * 4 + i % 4));
      chk("cont_valid", {31'b0, valid_out}, 32'h1);
      chk("cont_grant", {30'b0, grant},
          (i == 15) ? 32'h2 : ((nb % 2 == 0) ? 32'h1 : 32'h2));
    end
    tick();
    chk("cont_end_valid", {31'b0, valid_out}, 32'h0);
    chk("cont_end_grant", {30'b0, grant}, 32'h0);

    // req0 streams alone across a burst boundary
    en1 = 1'b0;
    q0[0] = 32'hFFFF_FFFF; q0[1] = 32'hEEEE_EEEE; q0[2] = 32'hDDDD_DDDD; q0[3] = 32'hCCCC_CCCC;
    q0[4] = 32'hFFFF_FFFF; q0[5] = 32'hEEEE_EEEE; q0[6] = 32'hDDDD_DDDD; q0[7] = 32'hCCCC_CCCC;
    idx0 = 0; n0 = 8; en0 = 1'b1; drive();
    tick();
    chk("solo_grant", {30'b0, grant}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("solo_data", data_out, q0[i]);
      chk("solo_valid", {31'b0, valid_out}, 32'h1);
      chk("solo_grant", {30'b0, grant}, 32'h1);
    end
    tick();
    chk("solo_end_valid", {31'b0, valid_out}, 32'h0);
    chk("solo_end_hold", data_out, 32'hCCCC_CCCC);
    chk("solo_end_grant", {30'b0, grant}, 32'h0);

    // req0 goes idle after 2 words while req1 waits
    for (int i = 0; i < 16; i++) begin
      q0[i] = 32'h4000_0000 + i;
      q1[i] = 32'h5000_0000 + i;
    end
    idx0 = 0; n0 = 2; idx1 = 0; n1 = 4; en0 = 1'b1; en1 = 1'b0; drive();
    tick();
    chk("drop_grant0", {30'b0, grant}, 32'h1);
    en1 = 1'b1; drive();
    tick();
    chk("drop_w0", data_out, 32'h4000_0000);
    tick();
    chk("drop_w1", data_out, 32'h4000_0001);
    tick();
    chk("drop_bubble", {31'b0, valid_out}, 32'h0);
    chk("drop_grant1", {30'b0, grant}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drop_r1_data", data_out, 32'h5000_0000 + i);
      chk("drop_r1_valid", {31'b0, valid_out}, 32'h1);
    end
    tick();
    chk("drop_end_grant", {30'b0, grant}, 32'h0);

    // Reset mid-burst, then INIT repeats and a fresh 4-word burst follows
    for (int i = 0; i < 16; i++) q0[i] = 32'h6000_0000 + i;
    q1[0] = 32'h7000_0001;
    idx0 = 0; n0 = 6; idx1 = 0; n1 = 1; en0 = 1'b1; en1 = 1'b0; drive();
    tick();
    tick();
    tick();
    chk("mid_w1", data_out, 32'h6000_0001);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, valid_out}, 32'h0);
    chk("mid_rst_grant", {30'b0, grant}, 32'h0);
    chk("mid_rst_ready", {31'b0, req0_ready}, 32'h0);
    chk("mid_rst_link", {31'b0, link_ready}, 32'h0);
    en1 = 1'b1; drive();
    tick(); tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("reinit_link", {31'b0, link_ready}, (k == 8) ? 32'h1 : 32'h0);
      chk("reinit_valid", {31'b0, valid_out}, 32'h0);
    end
    tick();
    chk("re_grant0", {30'b0, grant}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("re_data", data_out, 32'h6000_0002 + i);
      chk("re_valid", {31'b0, valid_out}, 32'h1);
    end
    chk("re_grant1", {30'b0, grant}, 32'h2);
    tick();
    chk("re_r1_data", data_out, 32'h7000_0001);
    tick();
    chk("re_end_grant", {30'b0, grant}, 32'h0);

    // BURST_MAX=1 instance: strict one-word alternation
    sel1 = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q0[i] = 32'h8000_0000 + i;
      q1[i] = 32'h9000_0000 + i;
    end
    idx0 = 0; idx1 = 0; n0 = 4; n1 = 4; en0 = 1'b1; en1 = 1'b1; drive();
    tick(); tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    chk("b1_link", {31'b0, d1_link}, 32'h1);
    tick();
    chk("b1_grant0", {30'b0, d1_grant}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b1_data", d1_data, (i % 2 == 0) ? (32'h8000_0000 + i / 2) : (32'h9000_0000 + i / 2));
      chk("b1_valid", {31'b0, d1_valid}, 32'h1);
      chk("b1_grant", {30'b0, d1_grant}, (i % 2 == 0) ? 32'h2 : 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
